// File: rtl/jbi_ncrd_nack_pkg.sv
// -----------------------------------------------------------------------------
// jbi_ncrd_nack_pkg
//
// Shared definitions for the NCRD nack controller (jbi_ncrd_nack_ctl).
//
// Contents:
//   NCRD_ID_W / NCRD_ID_N - width of an NCRD transaction ID and the number of IDs
//   HOLD_CYC_DEF          - default number of cycles that mout_nack is ignored
//                           after each pop
//   nack_state_e          - 2-bit encoding of the controller FSM states
//   ncrd_id_t             - NCRD transaction ID type
//   jbi_demux_4to16()     - one-hot decode of a 4-bit ID
// -----------------------------------------------------------------------------
package jbi_ncrd_nack_pkg;

  localparam int NCRD_ID_W    = 4;
  localparam int NCRD_ID_N    = 1 << NCRD_ID_W;
  localparam int HOLD_CYC_DEF = 2;

  // Controller states. The encoding is fixed so that it stays readable in
  // waveforms and matches the rest of the JBI nack logic.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for mout to report an NCRD timeout
    ST_RTN  = 2'd1,  // error return requested, waiting for the arbiter
    ST_POP  = 2'd2,  // one-cycle acknowledge back to mout
    ST_HOLD = 2'd3   // ignore the stale nack level while mout updates its flop
  } nack_state_e;

  typedef logic [NCRD_ID_W-1:0] ncrd_id_t;

  // One-hot decode of an NCRD ID into a 16-bit mask.
  function automatic logic [NCRD_ID_N-1:0] jbi_demux_4to16(input ncrd_id_t sel);
    logic [NCRD_ID_N-1:0] onehot;
    onehot      = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction

endpackage : jbi_ncrd_nack_pkg

// File: rtl/jbi_ncrd_nack_ctl.sv
// -----------------------------------------------------------------------------
// jbi_ncrd_nack_ctl
//
// Services NCRD timeout nacks raised by mout. For each pending nack the
// controller issues an error return to the ncio return arbiter, acknowledges
// the nack back to mout with a one-cycle pop, and then ignores the nack level
// for HOLD_CYC cycles because mout clears its nack through a register.
//
// Every nacked ID is remembered in nacked_mask so that read-return data that
// arrives late for that ID is discarded (drop_rtn_data). A mask bit is cleared
// by the late data itself or by a new NCRD that reuses the ID.
//
// Optional feature (macro JBI_NCRD_NACK_CNT_EN): when defined, adds the nack_cnt
// port carrying a saturating count of serviced nacks. When undefined the port
// and its counter do not exist; all other behaviour is unchanged.
//
// Parameters:
//   HOLD_CYC            cycles mout_nack is ignored after each pop
//
// Ports:
//   clk                 core clock
//   rst_l               asynchronous active-low reset
//   mout_nack           level: an NCRD timeout is pending in mout
//   nack_error_id[3:0]  ID of the pending timed-out NCRD (valid with mout_nack)
//   ncio_mout_nack_pop  one-cycle pulse acknowledging the nack to mout
//   err_rtn_vld         error-return request to the ncio return arbiter
//   err_rtn_id[3:0]     ID carried with err_rtn_vld
//   err_rtn_ack         arbiter accepts the error return this cycle
//   ncrd_sent           a new NCRD is issued with ncrd_id
//   ncrd_id[3:0]        ID of the new NCRD
//   rtn_data_seen       JBus read-return header seen for rtn_data_id
//   rtn_data_id[3:0]    ID of the read return
//   drop_rtn_data       combinational: current return targets a nacked ID
//   nacked_mask[15:0]   IDs that were nacked and have seen no late data yet
//   nack_cnt[7:0]       saturating count of nacks serviced (macro only)
// -----------------------------------------------------------------------------
module jbi_ncrd_nack_ctl
  import jbi_ncrd_nack_pkg::*;
#(
  parameter int unsigned HOLD_CYC = HOLD_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 mout_nack,
  input  logic [NCRD_ID_W-1:0] nack_error_id,
  output logic                 ncio_mout_nack_pop,
  output logic                 err_rtn_vld,
  output logic [NCRD_ID_W-1:0] err_rtn_id,
  input  logic                 err_rtn_ack,
  input  logic                 ncrd_sent,
  input  logic [NCRD_ID_W-1:0] ncrd_id,
  input  logic                 rtn_data_seen,
  input  logic [NCRD_ID_W-1:0] rtn_data_id,
  output logic                 drop_rtn_data,
  output logic [NCRD_ID_N-1:0] nacked_mask
`ifdef JBI_NCRD_NACK_CNT_EN
  ,
  output logic [7:0]           nack_cnt
`endif
);

  // Hold counter must be able to hold HOLD_CYC; keep at least one bit so the
  // HOLD_CYC = 0 build still elaborates.
  localparam int HOLD_W = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  nack_state_e          state_q, state_d;
  ncrd_id_t             id_q;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [NCRD_ID_N-1:0] mask_q, mask_d;
  logic                 capture;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of process ordering.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (mout_nack)   state_d = ST_RTN;
      ST_RTN:  if (err_rtn_ack) state_d = ST_POP;
      // With no hold window the nack can be re-sampled immediately.
      ST_POP:  state_d = (HOLD_CYC == 0) ? ST_IDLE : ST_HOLD;
      // Leave on the cycle the counter reaches zero; the "<=" also recovers a
      // counter that is already zero.
      ST_HOLD: if (hold_q <= HOLD_ONE) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (Moore, decoded from the registered state so that reset
  // clears them immediately)
  // ---------------------------------------------------------------------------
  always_comb begin
    err_rtn_vld        = 1'b0;
    ncio_mout_nack_pop = 1'b0;
    unique case (state_q)
      ST_RTN:  err_rtn_vld        = 1'b1;
      ST_POP:  ncio_mout_nack_pop = 1'b1;
      default: ;
    endcase
  end

  // id_q is only written in IDLE, so it is stable for the whole RTN window.
  assign err_rtn_id = id_q;

  // ---------------------------------------------------------------------------
  // Captured nack ID
  // ---------------------------------------------------------------------------
  assign capture = (state_q == ST_IDLE) && mout_nack;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      id_q <= '0;
    end else if (capture) begin
      id_q <= nack_error_id;
    end
  end

  // ---------------------------------------------------------------------------
  // Hold counter: loaded on the pop, counts the cycles in which the stale
  // mout_nack level must be ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    hold_d = hold_q;
    if (state_q == ST_POP) begin
      hold_d = HOLD_LOAD;
    end else if ((state_q == ST_HOLD) && (hold_q != '0)) begin
      hold_d = hold_q - HOLD_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Nacked-ID mask and late-data drop
  // ---------------------------------------------------------------------------
  // Data for an ID still in RTN is not dropped: its bit is only set by the pop.
  assign drop_rtn_data = rtn_data_seen & mask_q[rtn_data_id];

  // Clears are applied first and the pop set last, so a set and a clear of the
  // same ID in one cycle leave the bit set.
  always_comb begin
    mask_d = mask_q;
    if (ncrd_sent) begin
      mask_d = mask_d & ~jbi_demux_4to16(ncrd_id);
    end
    if (drop_rtn_data) begin
      mask_d = mask_d & ~jbi_demux_4to16(rtn_data_id);
    end
    if (state_q == ST_POP) begin
      mask_d = mask_d | jbi_demux_4to16(id_q);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign nacked_mask = mask_q;

`ifdef JBI_NCRD_NACK_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating count of serviced nacks (one per pop)
  // ---------------------------------------------------------------------------
  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q <= '0;
    end else if ((state_q == ST_POP) && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign nack_cnt = cnt_q;
`endif

endmodule : jbi_ncrd_nack_ctl

// File: tb/tb_jbi_ncrd_nack_ctl.sv
// -----------------------------------------------------------------------------
// tb_jbi_ncrd_nack_ctl
//
// Self-checking bench for jbi_ncrd_nack_ctl. A small model of mout holds the
// queue of timed-out NCRDs and presents the head as mout_nack/nack_error_id,
// clearing its nack one cycle after each pop (registered nack flop). Every nack
// handed to mout is also pushed into a scoreboard queue; a monitor on the
// falling edge pops it when the arbiter accepts an error return and keeps a
// reference model of the nacked-ID set, the drop decision and the nack count.
// Build with +define+JBI_NCRD_NACK_CNT_EN to cover the nack counter.
// -----------------------------------------------------------------------------
module tb_jbi_ncrd_nack_ctl;

  localparam int HOLD_CYC = 2;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        mout_nack;
  logic [3:0]  nack_error_id;
  logic        ncio_mout_nack_pop;
  logic        err_rtn_vld;
  logic [3:0]  err_rtn_id;
  logic        err_rtn_ack;
  logic        ncrd_sent;
  logic [3:0]  ncrd_id;
  logic        rtn_data_seen;
  logic [3:0]  rtn_data_id;
  logic        drop_rtn_data;
  logic [15:0] nacked_mask;
`ifdef JBI_NCRD_NACK_CNT_EN
  logic [7:0]  nack_cnt;
`endif

  jbi_ncrd_nack_ctl #(.HOLD_CYC(HOLD_CYC)) dut (
    .clk                (clk),
    .rst_l              (rst_l),
    .mout_nack          (mout_nack),
    .nack_error_id      (nack_error_id),
    .ncio_mout_nack_pop (ncio_mout_nack_pop),
    .err_rtn_vld        (err_rtn_vld),
    .err_rtn_id         (err_rtn_id),
    .err_rtn_ack        (err_rtn_ack),
    .ncrd_sent          (ncrd_sent),
    .ncrd_id            (ncrd_id),
    .rtn_data_seen      (rtn_data_seen),
    .rtn_data_id        (rtn_data_id),
    .drop_rtn_data      (drop_rtn_data),
    .nacked_mask        (nacked_mask)
`ifdef JBI_NCRD_NACK_CNT_EN
    ,
    .nack_cnt           (nack_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus-side state: mout model and arbiter ack policy
  // ---------------------------------------------------------------------------
  int unsigned nack_q[$];   // timed-out NCRDs still held by mout, head first
  int unsigned exp_q[$];    // scoreboard: IDs expected on accepted error returns
  int          pop_events = 0;  // written by the monitor only
  int          pop_used   = 0;  // written by the stimulus only
  int          ack_mode   = 0;  // 0: always ack, 1: random ack, 2: stall

  task automatic push_nack(input int unsigned id);
    nack_q.push_back(id);
    exp_q.push_back(id);
  endtask

  // Advance one cycle and drive this cycle's inputs just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    ncrd_sent     = 1'b0;
    rtn_data_seen = 1'b0;
    if (pop_events != pop_used) begin
      // mout saw the pop: it retires the head, but its registered nack level
      // (and ID) stay visible for one more cycle.
      pop_used = pop_events;
      if (nack_q.size() > 0) void'(nack_q.pop_front());
    end else begin
      mout_nack     = (nack_q.size() > 0);
      nack_error_id = (nack_q.size() > 0) ? 4'(nack_q[0]) : 4'd0;
    end
    case (ack_mode)
      0:       err_rtn_ack = 1'b1;
      2:       err_rtn_ack = 1'b0;
      default: err_rtn_ack = ($urandom_range(0, 2) != 0);
    endcase
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until err_rtn_vld is seen, bounded.
  task automatic wait_vld(input string name, input int max_cyc);
    int waited;
    waited = 0;
    while (!err_rtn_vld && waited < max_cyc) begin
      step();
      waited++;
    end
    if (!err_rtn_vld) check({name, "_vld_timeout"}, 32'(waited), 32'(max_cyc + 1));
  endtask

  // Step until mout and the scoreboard are empty and the controller is idle.
  task automatic drain(input int max_cyc);
    int waited;
    waited = 0;
    while ((nack_q.size() != 0 || exp_q.size() != 0 || err_rtn_vld) && waited < max_cyc) begin
      step();
      waited++;
    end
    check("drain_pending_nacks", 32'(nack_q.size() + exp_q.size()), 32'd0);
    steps(HOLD_CYC + 3);
  endtask

  task automatic apply_reset();
    rst_l         = 1'b0;
    nack_q.delete();
    mout_nack     = 1'b0;
    nack_error_id = 4'd0;
    ncrd_sent     = 1'b0;
    ncrd_id       = 4'd0;
    rtn_data_seen = 1'b0;
    rtn_data_id   = 4'd0;
    err_rtn_ack   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pop_used = pop_events;
    rst_l    = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor and reference model (falling edge)
  // ---------------------------------------------------------------------------
  logic [15:0] ref_mask;
  int          ref_cnt;
  logic        prev_vld, prev_ack, prev_acc;
  logic [3:0]  prev_id;
  int unsigned acc_id;
  logic        have_pop;
  int          last_pop_cyc;

  always @(negedge clk) begin
    if (!rst_l) begin
      exp_q.delete();
      ref_mask     = '0;
      ref_cnt      = 0;
      prev_vld     = 1'b0;
      prev_ack     = 1'b0;
      prev_acc     = 1'b0;
      prev_id      = 4'd0;
      acc_id       = 0;
      have_pop     = 1'b0;
      last_pop_cyc = 0;
    end else begin
      logic accept;
      accept = err_rtn_vld && err_rtn_ack;

      // An unacknowledged request must be held unchanged.
      if (prev_vld && !prev_ack) begin
        check("rtn_vld_held", 32'(err_rtn_vld), 32'd1);
        check("rtn_id_held", 32'(err_rtn_id), 32'(prev_id));
      end

      // Exactly one pop, in the cycle right after the accepted return.
      if (prev_acc || ncio_mout_nack_pop)
        check("pop_after_ack", 32'(ncio_mout_nack_pop), 32'(prev_acc));

      // A new request may not start inside the hold window after a pop.
      if (err_rtn_vld && !prev_vld && have_pop)
        check("hold_spacing_ok", 32'((cyc - last_pop_cyc) >= HOLD_CYC + 2), 32'd1);

      if (accept) begin
        if (exp_q.size() == 0) begin
          check("rtn_has_pending_nack", 32'(exp_q.size() != 0), 32'd1);
        end else begin
          acc_id = exp_q.pop_front();
          check("rtn_id", 32'(err_rtn_id), 32'(acc_id));
        end
      end

      check("drop_rtn_data", 32'(drop_rtn_data), 32'(rtn_data_seen & ref_mask[rtn_data_id]));
      check("nacked_mask", 32'(nacked_mask), 32'(ref_mask));
`ifdef JBI_NCRD_NACK_CNT_EN
      check("nack_cnt", 32'(nack_cnt), 32'(ref_cnt));
`endif

      // Reference update: clears first, the pop's set wins a same-ID clash.
      if (ncrd_sent)     ref_mask[ncrd_id]     = 1'b0;
      if (rtn_data_seen) ref_mask[rtn_data_id] = 1'b0;
      if (prev_acc) begin
        ref_mask[acc_id[3:0]] = 1'b1;
        ref_cnt               = (ref_cnt < 255) ? ref_cnt + 1 : 255;
        last_pop_cyc          = cyc;
        have_pop              = 1'b1;
      end
      if (ncio_mout_nack_pop) pop_events++;

      prev_vld = err_rtn_vld;
      prev_ack = err_rtn_ack;
      prev_acc = accept;
      prev_id  = err_rtn_id;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int c0, v1, v2, guard;

    // Reset state
    rst_l = 1'b0;
    #3;
    check("rst_err_rtn_vld", 32'(err_rtn_vld), 32'd0);
    check("rst_pop", 32'(ncio_mout_nack_pop), 32'd0);
    check("rst_err_rtn_id", 32'(err_rtn_id), 32'd0);
    check("rst_nacked_mask", 32'(nacked_mask), 32'd0);
    apply_reset();
    steps(2);

    // Single nack, id 5, immediate ack
    ack_mode = 0;
    push_nack(5);
    step();
    c0 = cyc;
    step();
    check("single_rtn_vld", 32'(err_rtn_vld), 32'd1);
    check("single_rtn_id", 32'(err_rtn_id), 32'd5);
    guard = 0;
    while (!ncio_mout_nack_pop && guard < 20) begin
      step();
      guard++;
    end
    check("nack_to_pop_cycles", 32'(cyc - c0 + 1), 32'd3);
    step();
    check("single_pop_width", 32'(ncio_mout_nack_pop), 32'd0);
    check("single_mask", 32'(nacked_mask), 32'h0020);
    steps(HOLD_CYC + 2);

    // Late data for nacked id 5 is dropped and clears the bit; id 6 is kept
    rtn_data_seen = 1'b1;
    rtn_data_id   = 4'd5;
    #2;
    check("late_drop_id5", 32'(drop_rtn_data), 32'd1);
    step();
    check("late_mask_cleared", 32'(nacked_mask[5]), 32'd0);
    rtn_data_seen = 1'b1;
    rtn_data_id   = 4'd6;
    #2;
    check("late_drop_id6", 32'(drop_rtn_data), 32'd0);
    step();

    // Ack stall: request held for 10 cycles, pop only after the ack
    ack_mode = 2;
    push_nack(7);
    step();
    wait_vld("stall", 10);
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_vld", 32'(err_rtn_vld), 32'd1);
      check("stall_id", 32'(err_rtn_id), 32'd7);
      check("stall_no_pop", 32'(ncio_mout_nack_pop), 32'd0);
    end
    ack_mode = 0;
    step();
    check("stall_ack_no_pop", 32'(ncio_mout_nack_pop), 32'd0);
    step();
    check("stall_pop", 32'(ncio_mout_nack_pop), 32'd1);
    drain(40);

    // Stale nack after the pop is not recaptured; next nack (id 9) follows HOLD
    push_nack(4);
    push_nack(9);
    step();
    wait_vld("stale_first", 10);
    v1 = cyc;
    step();
    wait_vld("stale_second", 20);
    v2 = cyc;
    check("back_to_back_spacing", 32'(v2 - v1), 32'(3 + HOLD_CYC));
    check("stale_second_id", 32'(err_rtn_id), 32'd9);
    drain(40);

    // ID reuse collision: ncrd_sent id 3 in the POP cycle of id 3
    push_nack(3);
    step();           // IDLE captures
    step();           // RTN, acked
    step();           // POP
    check("collision_pop", 32'(ncio_mout_nack_pop), 32'd1);
    ncrd_sent = 1'b1;
    ncrd_id   = 4'd3;
    step();
    check("collision_set_wins", 32'(nacked_mask[3]), 32'd1);
    drain(40);

    // Reset asserted mid-RTN: outputs clear at once, no pop follows
    ack_mode = 2;
    push_nack(11);
    step();
    wait_vld("reset_rtn", 10);
    #1;
    rst_l = 1'b0;
    #1;
    check("midrst_vld", 32'(err_rtn_vld), 32'd0);
    check("midrst_pop", 32'(ncio_mout_nack_pop), 32'd0);
    check("midrst_id", 32'(err_rtn_id), 32'd0);
    check("midrst_mask", 32'(nacked_mask), 32'd0);
`ifdef JBI_NCRD_NACK_CNT_EN
    check("midrst_cnt", 32'(nack_cnt), 32'd0);
`endif
    apply_reset();
    ack_mode = 0;
    steps(3);
    check("midrst_no_pop_after", 32'(ncio_mout_nack_pop), 32'd0);

`ifdef JBI_NCRD_NACK_CNT_EN
    // 300 nacks saturate the counter
    for (int i = 0; i < 300; i++) push_nack($urandom_range(0, 15));
    drain(300 * (3 + HOLD_CYC) + 50);
    check("cnt_saturated", 32'(nack_cnt), 32'hFF);
`endif

    // Randomized traffic
    ack_mode = 1;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (($urandom_range(0, 7) == 0) && (nack_q.size() < 4)) push_nack($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) begin
        ncrd_sent = 1'b1;
        ncrd_id   = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 3) == 0) begin
        rtn_data_seen = 1'b1;
        rtn_data_id   = 4'($urandom_range(0, 15));
      end
    end
    drain(400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound in case a wait above misbehaves.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (checks %0d, errors %0d)", n_checks, n_errors);
    $fatal(1);
  end

endmodule : tb_jbi_ncrd_nack_ctl
